// File: rtl/parity_frame_checker.sv
// Serial frame receiver: collects NUM_BITS data bits, checks a trailing parity bit,
// and reports the word, parity/framing errors and a saturating error count.
module parity_frame_checker #(
  parameter int unsigned NUM_BITS        = 4,
  parameter bit          EVEN_PARITY_BIT = 1'b1,
  parameter bit          MSB_FIRST       = 1'b1,
  parameter int unsigned ERR_CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 data_in,
  input  logic                 wr_en,
  input  logic                 parity_in,
  input  logic                 parity_en,
  input  logic                 clr_count,
  output logic [NUM_BITS-1:0]  word_out,
  output logic                 word_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int unsigned CNT_W = $clog2(NUM_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BITS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FULL    = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_BITS-1:0]    shift_q, shift_d;
  logic                   par_q, par_d;
  logic [NUM_BITS-1:0]    word_q, word_d;
  logic                   valid_q, valid_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic [NUM_BITS-1:0]    shift_ins;
  logic                   exp_par;
  logic                   to_idle;
  logic                   err_evt;

  // Shift register with the incoming bit inserted at the end chosen by MSB_FIRST;
  // the shift register is cleared whenever a frame closes, so IDLE starts from zero.
  generate
    if (NUM_BITS == 1) begin : g_single
      assign shift_ins = data_in;
    end else if (MSB_FIRST) begin : g_msb_first
      assign shift_ins = {shift_q[NUM_BITS-2:0], data_in};
    end else begin : g_lsb_first
      assign shift_ins = {data_in, shift_q[NUM_BITS-1:1]};
    end
  endgenerate

  assign exp_par = EVEN_PARITY_BIT ? par_q : ~par_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    par_d   = par_q;
    word_d  = word_q;
    valid_d = 1'b0;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
    to_idle = 1'b0;

    if (wr_en && parity_en) begin
      ferr_d  = 1'b1;
      to_idle = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (wr_en) begin
            shift_d = shift_ins;
            cnt_d   = CNT_W'(1);
            par_d   = data_in;
            state_d = (NUM_BITS == 1) ? FULL : COLLECT;
          end else if (parity_en) begin
            ferr_d  = 1'b1;
            to_idle = 1'b1;
          end
        end
        COLLECT: begin
          if (wr_en) begin
            shift_d = shift_ins;
            cnt_d   = cnt_q + 1'b1;
            par_d   = par_q ^ data_in;
            if (cnt_q + 1'b1 == LAST_CNT) begin
              state_d = FULL;
            end
          end else if (parity_en) begin
            ferr_d  = 1'b1;
            to_idle = 1'b1;
          end
        end
        FULL: begin
          if (parity_en) begin
            word_d  = shift_q;
            valid_d = 1'b1;
            perr_d  = (parity_in != exp_par);
            to_idle = 1'b1;
          end else if (wr_en) begin
            ferr_d  = 1'b1;
            to_idle = 1'b1;
          end
        end
        default: begin
          to_idle = 1'b1;
        end
      endcase
    end

    // Closing a frame, good or bad, always leaves a clean IDLE context.
    if (to_idle) begin
      state_d = IDLE;
      cnt_d   = '0;
      shift_d = '0;
      par_d   = 1'b0;
    end
  end

  assign err_evt = perr_d | ferr_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (clr_count) begin
      err_cnt_d = '0;
    end else if (err_evt && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      word_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      word_q    <= word_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign word_out   = word_q;
  assign word_valid = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign err_count  = err_cnt_q;

endmodule
